// File: rtl/pong_game_ctrl.sv
// Pong match sequencer: holds the ball in reset between rallies, gates the
// per-frame ball update, keeps both scores and declares the winner.
module pong_game_ctrl #(
  parameter int unsigned SERVE_FRAMES = 60,
  parameter int unsigned WIN_SCORE    = 7,
  parameter int unsigned SCORE_W      = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               frame_tick,
  input  logic               left_scored,
  input  logic               right_scored,
  output logic               ball_reset,
  output logic               ball_update,
  output logic [SCORE_W-1:0] left_score,
  output logic [SCORE_W-1:0] right_score,
  output logic               game_over,
  output logic               winner,
  output logic               serving
);

  localparam int unsigned CNT_W = (SERVE_FRAMES < 2) ? 1 : $clog2(SERVE_FRAMES + 1);
  localparam logic [CNT_W-1:0]   SERVE_LOAD = CNT_W'(SERVE_FRAMES);
  localparam logic [SCORE_W-1:0] WIN        = SCORE_W'(WIN_SCORE);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SERVE,
    S_PLAY,
    S_POINT,
    S_OVER
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] serve_cnt;

  // Ball may only move on a frame tick during live play and while not paused
  assign ball_update = (state == S_PLAY) & frame_tick & ~pause;

  // Match FSM; ball_reset/serving/game_over are registered alongside the
  // state so they always equal the decode of the state being entered
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      serve_cnt   <= '0;
      left_score  <= '0;
      right_score <= '0;
      winner      <= 1'b0;
      game_over   <= 1'b0;
      serving     <= 1'b0;
      ball_reset  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state     <= S_SERVE;
            serve_cnt <= SERVE_LOAD;
            serving   <= 1'b1;
          end
        end

        S_SERVE: begin
          if (frame_tick) begin
            if (serve_cnt != '0) begin
              serve_cnt <= serve_cnt - CNT_W'(1);
            end
            if (serve_cnt == CNT_W'(1)) begin
              state      <= S_PLAY;
              serving    <= 1'b0;
              ball_reset <= 1'b0;
            end
          end
        end

        S_PLAY: begin
          if (left_scored) begin
            if (left_score < WIN) begin
              left_score <= left_score + SCORE_W'(1);
            end
            state      <= S_POINT;
            ball_reset <= 1'b1;
          end else if (right_scored) begin
            if (right_score < WIN) begin
              right_score <= right_score + SCORE_W'(1);
            end
            state      <= S_POINT;
            ball_reset <= 1'b1;
          end
        end

        S_POINT: begin
          if ((left_score == WIN) || (right_score == WIN)) begin
            state     <= S_OVER;
            winner    <= (right_score == WIN);
            game_over <= 1'b1;
          end else begin
            state     <= S_SERVE;
            serve_cnt <= SERVE_LOAD;
            serving   <= 1'b1;
          end
        end

        S_OVER: begin
          if (start) begin
            left_score  <= '0;
            right_score <= '0;
            winner      <= 1'b0;
            serve_cnt   <= SERVE_LOAD;
            state       <= S_SERVE;
            serving     <= 1'b1;
            game_over   <= 1'b0;
          end
        end

        default: begin
          state      <= S_IDLE;
          serving    <= 1'b0;
          game_over  <= 1'b0;
          ball_reset <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Bench for pong_game_ctrl: directed vector table followed by random play
// checked against a behavioural match model.
module tb_pong_game_ctrl;

  localparam int SF = 3;
  localparam int W  = 3;
  localparam int SW = 4;

  logic          clock = 1'b0;
  logic          reset, start, pause, frame_tick, left_scored, right_scored;
  logic          ball_reset, ball_update, game_over, winner, serving;
  logic [SW-1:0] left_score, right_score;

  int total = 0;
  int bad   = 0;

  pong_game_ctrl #(.SERVE_FRAMES(SF), .WIN_SCORE(W), .SCORE_W(SW)) dut (
    .clock(clock), .reset(reset), .start(start), .pause(pause),
    .frame_tick(frame_tick), .left_scored(left_scored), .right_scored(right_scored),
    .ball_reset(ball_reset), .ball_update(ball_update),
    .left_score(left_score), .right_score(right_score),
    .game_over(game_over), .winner(winner), .serving(serving)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0d: got %0d expected %0d", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic rst, st, pa, ft, lf, rf);
    @(negedge clock);
    reset = rst; start = st; pause = pa;
    frame_tick = ft; left_scored = lf; right_scored = rf;
    #1;
  endtask

  task automatic chk_regs(input int idx, input logic br, sv, go, wn, input int l, r);
    chk("ball_reset", idx, ball_reset, br);
    chk("serving", idx, serving, sv);
    chk("game_over", idx, game_over, go);
    chk("winner", idx, winner, wn);
    chk("left_score", idx, left_score, l);
    chk("right_score", idx, right_score, r);
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic rst, st, pa, ft, lf, rf;
    logic bu;
    logic br, sv, go, wn;
    int   l, r;
  } vec_t;

  vec_t vq[$];

  function automatic void add(input logic rst, st, pa, ft, lf, rf, bu, br, sv, go, wn,
                              input int l, r);
    vec_t v;
    v.rst = rst; v.st = st; v.pa = pa; v.ft = ft; v.lf = lf; v.rf = rf;
    v.bu = bu; v.br = br; v.sv = sv; v.go = go; v.wn = wn; v.l = l; v.r = r;
    vq.push_back(v);
  endfunction

  // Three serve ticks: SERVE, SERVE, then PLAY
  function automatic void ticks3(input int l, r);
    add(0,0,0,1,0,0, 0, 1,1,0,0, l,r);
    add(0,0,0,1,0,0, 0, 1,1,0,0, l,r);
    add(0,0,0,1,0,0, 0, 0,0,0,0, l,r);
  endfunction

  // Flag in PLAY -> POINT, then back to SERVE (non-winning point)
  function automatic void score_serve(input logic lf, rf, input int l, r);
    add(0,0,0,0,lf,rf, 0, 1,0,0,0, l,r);
    add(0,0,0,0,0,0,   0, 1,1,0,0, l,r);
  endfunction

  // ---------------- reference model ----------------
  bit m_idle = 1, m_over = 0, m_point = 0, m_win = 0;
  int m_srv = 0, m_l = 0, m_r = 0;

  function automatic bit m_play();
    return !m_idle && !m_over && !m_point && (m_srv == 0);
  endfunction

  function automatic void m_step(input logic rst, st, ft, lf, rf);
    if (rst) begin
      m_idle = 1; m_over = 0; m_point = 0; m_win = 0; m_srv = 0; m_l = 0; m_r = 0;
    end else if (m_idle) begin
      if (st) begin m_idle = 0; m_srv = SF; end
    end else if (m_over) begin
      if (st) begin m_over = 0; m_l = 0; m_r = 0; m_win = 0; m_srv = SF; end
    end else if (m_point) begin
      m_point = 0;
      if (m_l == W || m_r == W) begin m_over = 1; m_win = (m_r == W); end
      else m_srv = SF;
    end else if (m_srv > 0) begin
      if (ft) m_srv--;
    end else begin
      if (lf) begin m_l = (m_l < W) ? m_l + 1 : m_l; m_point = 1; end
      else if (rf) begin m_r = (m_r < W) ? m_r + 1 : m_r; m_point = 1; end
    end
  endfunction

  initial begin
    reset = 1; start = 0; pause = 0; frame_tick = 0; left_scored = 0; right_scored = 0;

    // reset hold, idle ticks, flags in idle ignored
    add(1,0,0,0,0,0, 0, 1,0,0,0, 0,0);
    add(1,0,0,1,0,0, 0, 1,0,0,0, 0,0);
    for (int i = 0; i < 10; i++) add(0,0,0,1,0,0, 0, 1,0,0,0, 0,0);
    add(0,0,1,1,1,1, 0, 1,0,0,0, 0,0);
    // start and serve timing; start/pause/flags ignored in SERVE
    add(0,1,0,0,0,0, 0, 1,1,0,0, 0,0);
    add(0,1,1,1,1,0, 0, 1,1,0,0, 0,0);
    add(0,0,0,0,0,0, 0, 1,1,0,0, 0,0);
    add(0,0,0,1,0,0, 0, 1,1,0,0, 0,0);
    add(0,0,0,1,0,0, 0, 0,0,0,0, 0,0);
    add(0,1,0,1,0,0, 1, 0,0,0,0, 0,0);
    // right point held two cycles: counted once
    add(0,0,0,0,0,1, 0, 1,0,0,0, 0,1);
    add(0,0,0,0,0,1, 0, 1,1,0,0, 0,1);
    add(0,0,0,1,0,1, 0, 1,1,0,0, 0,1);
    add(0,0,0,1,0,0, 0, 1,1,0,0, 0,1);
    add(0,0,0,1,0,0, 0, 0,0,0,0, 0,1);
    // pause gates update only
    for (int i = 0; i < 5; i++) add(0,0,1,1,0,0, 0, 0,0,0,0, 0,1);
    add(0,0,0,1,0,0, 1, 0,0,0,0, 0,1);
    // left to 2, then simultaneous flags win for left
    score_serve(1,0, 1,1);
    ticks3(1,1);
    score_serve(1,0, 2,1);
    ticks3(2,1);
    add(0,0,0,1,1,1, 1, 1,0,0,0, 3,1);
    add(0,0,0,0,0,0, 0, 1,0,1,0, 3,1);
    add(0,0,0,1,1,1, 0, 1,0,1,0, 3,1);
    add(0,1,0,0,0,0, 0, 1,1,0,0, 0,0);
    // build 1/2 in PLAY, then reset with coincident start
    ticks3(0,0);
    score_serve(0,1, 0,1);
    ticks3(0,1);
    score_serve(0,1, 0,2);
    ticks3(0,2);
    score_serve(1,0, 1,2);
    ticks3(1,2);
    add(1,1,0,1,0,0, 1, 1,0,0,0, 0,0);
    add(0,0,0,1,0,0, 0, 1,0,0,0, 0,0);
    // right wins 0/3, then restart clears winner
    add(0,1,0,0,0,0, 0, 1,1,0,0, 0,0);
    ticks3(0,0);
    score_serve(0,1, 0,1);
    ticks3(0,1);
    score_serve(0,1, 0,2);
    ticks3(0,2);
    add(0,0,0,0,0,1, 0, 1,0,0,0, 0,3);
    add(0,0,0,0,0,0, 0, 1,0,1,1, 0,3);
    add(0,1,0,0,0,0, 0, 1,1,0,0, 0,0);

    // initial reset edge establishes a known state before the table
    drive(1,0,0,0,0,0);
    @(posedge clock);

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].st, vq[i].pa, vq[i].ft, vq[i].lf, vq[i].rf);
      chk("ball_update", i, ball_update, vq[i].bu);
      @(posedge clock); #1;
      chk_regs(i, vq[i].br, vq[i].sv, vq[i].go, vq[i].wn, vq[i].l, vq[i].r);
    end

    // random play against the model
    drive(1,0,0,0,0,0);
    @(posedge clock); #1;
    m_step(1,0,0,0,0);
    chk_regs(-1, 1, 0, 0, 0, 0, 0);

    for (int c = 0; c < 3000; c++) begin
      logic rst, st, pa, ft, lf, rf;
      rst = ($urandom_range(0,149) == 0);
      st  = ($urandom_range(0,15) == 0);
      pa  = ($urandom_range(0,3) == 0);
      ft  = ($urandom_range(0,2) == 0);
      lf  = ($urandom_range(0,9) == 0);
      rf  = ($urandom_range(0,9) == 0);
      drive(rst, st, pa, ft, lf, rf);
      chk("rnd_ball_update", c, ball_update, m_play() && ft && !pa);
      @(posedge clock); #1;
      m_step(rst, st, ft, lf, rf);
      chk_regs(c, !m_play(), m_srv > 0, m_over, m_win, m_l, m_r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
